// File: rtl/uart_rx_word_packer_pkg.sv
// Shared types for the UART receive word packer: byte/word types and byte-lane mapping.
// No logic; no latency; no backpressure.
// Lane mapping is the only place that knows about byte order.
package uart_word_pkg;
    localparam int BYTES_PER_WORD = 4;

    typedef logic [7:0]  byte_t;
    typedef logic [31:0] word_t;
    typedef logic [1:0]  lane_idx_t;

    function automatic lane_idx_t lane_of(input lane_idx_t idx, input bit msb_first);
        return msb_first ? lane_idx_t'(BYTES_PER_WORD - 1) - idx : idx;
    endfunction
endpackage

// File: rtl/uart_rx_word_packer_if.sv
// Byte-in / word-out bundle between the UART receiver, the packer and the core.
// Pure wiring; no latency.
// Core-side pop is the only flow control; byte side has none (overruns are flagged).
interface uart_rx_word_packer_if #(
    parameter int DEPTH = 4
);
    import uart_word_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);

    logic          wb_flag;
    byte_t         wb_data;
    logic          pop;
    logic          clear_ovf;
    word_t         word_out;
    logic          word_valid;
    logic [CW-1:0] word_count;
    logic [1:0]    partial_bytes;
    logic          overflow;

    modport master (
        output wb_flag, wb_data, pop, clear_ovf,
        input  word_out, word_valid, word_count, partial_bytes, overflow
    );

    modport slave (
        input  wb_flag, wb_data, pop, clear_ovf,
        output word_out, word_valid, word_count, partial_bytes, overflow
    );
endinterface

// File: rtl/uart_rx_word_packer_fifo.sv
// Synchronous show-ahead FIFO: head entry presented on dout while not empty (zero when empty).
// Latency: push visible on dout the cycle after it is written.
// Push while full is accepted only if a pop frees a slot the same cycle; pop while empty is ignored.
module uart_word_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [31:0]
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  T                             din,
    output T                             dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH + 1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    T              mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_pop;
    logic          do_push;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        dout = '0;
        if (!empty) dout = mem[rd_ptr];
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers rely on DEPTH being a power of two for natural wrap.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/uart_rx_word_packer.sv
// Packs UART bytes (one per wb_flag rising edge) into 32-bit words queued in a show-ahead FIFO.
// Latency: 4th byte strobe in cycle N -> word at FIFO head in N+1. Optional partial flush: UART_RX_TIMEOUT_FLUSH_EN.
// No backpressure to the UART: a completed word arriving at a full FIFO (no pop) is dropped and sets sticky overflow.
module uart_rx_word_packer
    import uart_word_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter bit MSB_FIRST      = 1'b0,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                 clock,
    input  logic                 reset,
    uart_rx_word_packer_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);

    logic          prev_flag;
    lane_idx_t     byte_idx;
    word_t         lanes;
    word_t         merged;
    word_t         push_word;
    logic          byte_stb;
    logic          complete;
    logic          flush;
    logic          push;
    logic          drop;
    logic          full;
    logic          empty;
    logic          overflow_q;
    logic [CW-1:0] count;

    assign byte_stb = bus.wb_flag & ~prev_flag;
    assign complete = byte_stb & (byte_idx == lane_idx_t'(BYTES_PER_WORD - 1));

    always_comb begin
        merged = lanes;
        merged[8*int'(lane_of(byte_idx, MSB_FIRST)) +: 8] = bus.wb_data;
    end

`ifdef UART_RX_TIMEOUT_FLUSH_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] idle_cnt;

    // A byte arriving in the timeout cycle takes priority over the flush.
    assign flush = ~byte_stb & (byte_idx != '0) & (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset || byte_stb || flush) begin
            idle_cnt <= '0;
        end else if (byte_idx != '0) begin
            idle_cnt <= idle_cnt + TW'(1);
        end
    end
`else
    assign flush = 1'b0;
`endif

    assign push      = complete | flush;
    assign push_word = complete ? merged : lanes;
    assign drop      = push & full & ~bus.pop;

    always_ff @(posedge clock) begin
        if (reset) begin
            prev_flag  <= 1'b0;
            byte_idx   <= '0;
            lanes      <= '0;
            overflow_q <= 1'b0;
        end else begin
            prev_flag <= bus.wb_flag;
            // A push always realigns the stream, even if the word is dropped.
            if (push) begin
                byte_idx <= '0;
                lanes    <= '0;
            end else if (byte_stb) begin
                byte_idx <= byte_idx + lane_idx_t'(1);
                lanes    <= merged;
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (bus.clear_ovf) begin
                overflow_q <= 1'b0;
            end
        end
    end

    uart_word_fifo #(
        .DEPTH (DEPTH),
        .T     (word_t)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (bus.pop),
        .din   (push_word),
        .dout  (bus.word_out),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign bus.word_valid    = ~empty;
    assign bus.word_count    = count;
    assign bus.partial_bytes = byte_idx;
    assign bus.overflow      = overflow_q;
endmodule
